// File: rtl/wb_ic_pkg.sv
// Shared types and defaults for the Wishbone shared-bus interconnect.
// Holds the FSM state encoding, arbitration mode codes and default decode map.
package wb_ic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ERR  = 2'd2
  } ic_state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam logic [95:0] DEF_SLAVE_BASE = {32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [95:0] DEF_SLAVE_MASK = {3{32'hFFFF_0000}};

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Master arbiter: one-hot grant from the request vector, searching from rr_ptr
// (round-robin) or from index 0 (fixed priority).
module wb_rr_arbiter
  import wb_ic_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ARB_MODE    = ARB_RR
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   release_en,
  input  logic [NUM_MASTERS-1:0] release_grant,
  output logic [NUM_MASTERS-1:0] grant
);

  localparam int IW = idx_width(NUM_MASTERS);

  logic [IW-1:0] rr_ptr_reg;
  logic [IW-1:0] rr_ptr_next;
  logic [IW-1:0] rel_idx;
  int            start_idx;
  int            cand;

  always_comb begin
    rel_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (release_grant[i]) rel_idx = IW'(i);
    end
    rr_ptr_next = rr_ptr_reg;
    if (release_en) begin
      rr_ptr_next = (rel_idx == IW'(NUM_MASTERS - 1)) ? '0 : rel_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) rr_ptr_reg <= '0;
    else        rr_ptr_reg <= rr_ptr_next;
  end

  // First requester found walking upward (with wrap) from the start index wins.
  always_comb begin
    grant     = '0;
    start_idx = (ARB_MODE == ARB_FIXED) ? 0 : int'(rr_ptr_reg);
    cand      = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = start_idx + i;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (grant == '0 && req[cand]) grant[cand] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_interconnect.sv
// Shared-bus Wishbone interconnect: N masters arbitrated onto one bus,
// address-decoded to M slaves, with decode-miss and no-ack timeout errors.
module wb_interconnect
  import wb_ic_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 3,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_SEL_WIDTH   = 4,
  parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
  parameter int ARB_MODE       = ARB_RR,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] m_data_i,
  input  logic [NUM_MASTERS-1:0]               m_we_i,
  input  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]               m_stb_i,
  input  logic [NUM_MASTERS-1:0]               m_cyc_i,
  output logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] m_data_o,
  output logic [NUM_MASTERS-1:0]               m_ack_o,
  output logic [NUM_MASTERS-1:0]               m_err_o,
  output logic [WB_ADDR_WIDTH-1:0]             s_addr_o,
  output logic [WB_DATA_WIDTH-1:0]             s_data_o,
  output logic                                 s_we_o,
  output logic [WB_SEL_WIDTH-1:0]              s_sel_o,
  output logic [NUM_SLAVES-1:0]                s_stb_o,
  output logic [NUM_SLAVES-1:0]                s_cyc_o,
  input  logic [NUM_SLAVES-1:0]                s_ack_i,
  input  logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]  s_data_i,
  output logic [NUM_MASTERS-1:0]               grant_o
);

  localparam int MW  = idx_width(NUM_MASTERS);
  localparam int SIW = idx_width(NUM_SLAVES);
  localparam int TW  = idx_width(TIMEOUT_CYCLES);

  ic_state_e              state_reg, state_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next, arb_grant;
  logic [TW-1:0]          tmo_reg, tmo_next;
  logic                   release_en;

  logic [MW-1:0]            g_idx;
  logic [WB_ADDR_WIDTH-1:0] g_addr;
  logic [WB_DATA_WIDTH-1:0] g_data;
  logic [WB_SEL_WIDTH-1:0]  g_sel;
  logic                     g_we, g_stb, g_cyc;

  logic [NUM_SLAVES-1:0]    hit_vec;
  logic [SIW-1:0]           hit_idx;
  logic                     hit_any, hit_ack;
  logic                     bus_act, err_act;

  wb_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .ARB_MODE    (ARB_MODE)
  ) u_arb (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req           (m_cyc_i),
    .release_en    (release_en),
    .release_grant (grant_reg),
    .grant         (arb_grant)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_reg[i]) g_idx = MW'(i);
    end
  end

  assign g_addr = m_addr_i[g_idx*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
  assign g_data = m_data_i[g_idx*WB_DATA_WIDTH +: WB_DATA_WIDTH];
  assign g_sel  = m_sel_i[g_idx*WB_SEL_WIDTH +: WB_SEL_WIDTH];
  assign g_we   = m_we_i[g_idx];
  assign g_stb  = m_stb_i[g_idx] & (|grant_reg);
  assign g_cyc  = m_cyc_i[g_idx] & (|grant_reg);

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
    assign hit_vec[gi] = (g_addr & SLAVE_MASK[gi*WB_ADDR_WIDTH +: WB_ADDR_WIDTH])
                         == SLAVE_BASE[gi*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
  end

  // Walk downward so overlapping windows resolve to the lowest slave index.
  always_comb begin
    hit_idx = '0;
    for (int j = NUM_SLAVES - 1; j >= 0; j--) begin
      if (hit_vec[j]) hit_idx = SIW'(j);
    end
  end

  assign hit_any = |hit_vec;
  assign hit_ack = hit_any & s_ack_i[hit_idx];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      tmo_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      tmo_reg   <= tmo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    tmo_next   = '0;
    release_en = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|m_cyc_i) begin
          grant_next = arb_grant;
          state_next = BUS;
        end
      end
      BUS: begin
        if (!g_cyc) begin
          state_next = IDLE;
          grant_next = '0;
          release_en = 1'b1;
        end else if (g_stb && !hit_any) begin
          state_next = ERR;
        end else if (g_stb && !hit_ack) begin
          if (tmo_reg == TW'(TIMEOUT_CYCLES - 1)) state_next = ERR;
          else                                    tmo_next   = tmo_reg + 1'b1;
        end
      end
      ERR: begin
        if (g_cyc) begin
          state_next = BUS;
        end else begin
          state_next = IDLE;
          grant_next = '0;
          release_en = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // Qualifying with rst_i silences the bus in the very cycle reset is applied.
  assign bus_act = rst_i && (state_reg == BUS);
  assign err_act = rst_i && (state_reg == ERR);

  always_comb begin
    s_addr_o = bus_act ? g_addr : '0;
    s_data_o = bus_act ? g_data : '0;
    s_sel_o  = bus_act ? g_sel  : '0;
    s_we_o   = bus_act & g_we;
    s_stb_o  = '0;
    s_cyc_o  = '0;
    m_ack_o  = '0;
    m_err_o  = '0;
    m_data_o = '0;
    if (bus_act && hit_any) begin
      s_stb_o[hit_idx] = g_stb;
      s_cyc_o[hit_idx] = g_cyc;
      m_ack_o[g_idx]   = hit_ack;
      m_data_o[g_idx*WB_DATA_WIDTH +: WB_DATA_WIDTH] = s_data_i[hit_idx*WB_DATA_WIDTH +: WB_DATA_WIDTH];
    end
    if (err_act) m_err_o[g_idx] = 1'b1;
  end

  assign grant_o = grant_reg;

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed and randomized bench for wb_interconnect; a transaction-level model
// predicts grant order, decode target, read data and error pulses.
module tb_wb_interconnect;
  import wb_ic_pkg::*;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM-1:0]     m_we, m_stb, m_cyc;
  logic [NM*SW-1:0]  m_sel;
  logic [NM*DW-1:0]  m_rdata, fx_m_rdata;
  logic [NM-1:0]     m_ack, m_err, grant, fx_ack, fx_err, fx_grant;
  logic [AW-1:0]     s_addr, fx_s_addr;
  logic [DW-1:0]     s_wdata, fx_s_wdata;
  logic              s_we, fx_s_we;
  logic [SW-1:0]     s_sel, fx_s_sel;
  logic [NS-1:0]     s_stb, s_cyc, fx_s_stb, fx_s_cyc, s_ack;
  logic [NS*DW-1:0]  s_rdata;
  logic [31:0]       tag;

  int checks   = 0;
  int failures = 0;
  int exp_ptr  = 0;
  logic [31:0] wd_m [NM];
  logic        we_m [NM];
  logic [31:0] addr_m [NM];

  for (genvar gj = 0; gj < NS; gj++) begin : g_slave
    assign s_rdata[gj*DW +: DW] = (32'hC000_0000 + (32'(gj) << 24)) ^ tag;
  end

  wb_interconnect dut (
    .clk_i(clk), .rst_i(rst_n),
    .m_addr_i(m_addr), .m_data_i(m_wdata), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_stb_i(m_stb), .m_cyc_i(m_cyc),
    .m_data_o(m_rdata), .m_ack_o(m_ack), .m_err_o(m_err),
    .s_addr_o(s_addr), .s_data_o(s_wdata), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_ack_i(s_ack), .s_data_i(s_rdata),
    .grant_o(grant)
  );

  wb_interconnect #(.ARB_MODE(ARB_FIXED)) dut_fx (
    .clk_i(clk), .rst_i(rst_n),
    .m_addr_i(m_addr), .m_data_i(m_wdata), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_stb_i(m_stb), .m_cyc_i(m_cyc),
    .m_data_o(fx_m_rdata), .m_ack_o(fx_ack), .m_err_o(fx_err),
    .s_addr_o(fx_s_addr), .s_data_o(fx_s_wdata), .s_we_o(fx_s_we), .s_sel_o(fx_s_sel),
    .s_stb_o(fx_s_stb), .s_cyc_o(fx_s_cyc), .s_ack_i(s_ack), .s_data_i(s_rdata),
    .grant_o(fx_grant)
  );

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      $error("check %s", name);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic [31:0] addr);
    m_cyc[m] = cyc;
    m_stb[m] = stb;
    m_addr[m*AW +: AW] = addr;
    wd_m[m] = $urandom;
    we_m[m] = 1'($urandom_range(0, 1));
    addr_m[m] = addr;
    m_wdata[m*DW +: DW] = wd_m[m];
    m_we[m] = we_m[m];
    m_sel[m*SW +: SW] = 4'hF;
  endtask

  // Decode map in plain arithmetic: 64 KiB windows at 0, 1 and 2.
  function automatic int exp_slave(input logic [31:0] addr);
    int hi;
    hi = int'(addr >> 16);
    return (hi < NS) ? hi : -1;
  endfunction

  function automatic logic [31:0] slave_word(input int j);
    return (32'hC000_0000 + (32'(j) << 24)) ^ tag;
  endfunction

  function automatic int pick(input logic [NM-1:0] pend);
    for (int i = 0; i < NM; i++) begin
      if (pend[(exp_ptr + i) % NM]) return (exp_ptr + i) % NM;
    end
    return -1;
  endfunction

  task automatic hit_xfer(input int w, input int lat);
    int sl;
    logic [NM*DW-1:0] e;
    sl = exp_slave(addr_m[w]);
    for (int k = 0; k < lat; k++) begin
      chk("wait_stb", s_stb, 128'(1 << sl));
      chk("wait_noack", m_ack, 0);
      step();
    end
    tag = $urandom;
    s_ack = NS'(1 << sl);
    #1;
    e = '0;
    e[w*DW +: DW] = slave_word(sl);
    chk("ack_vec", m_ack, 128'(1 << w));
    chk("rdata", m_rdata, e);
    chk("noerr_on_ack", m_err, 0);
    chk("s_fwd", {s_addr, s_wdata, s_we, s_sel}, {addr_m[w], wd_m[w], we_m[w], 4'hF});
    chk("s_cyc", s_cyc, 128'(1 << sl));
    step();
    s_ack = '0;
  endtask

  task automatic err_xfer(input int w);
    chk("miss_nostb", s_stb, 0);
    chk("miss_noerr_bus", m_err, 0);
    step();
    chk("err_pulse", m_err, 128'(1 << w));
    chk("err_noack", m_ack, 0);
    chk("err_nostb", {s_stb, s_cyc}, 0);
    chk("err_grant", grant, 128'(1 << w));
  endtask

  task automatic release_m(input int w);
    set_m(w, 1'b0, 1'b0, 32'h0);
    exp_ptr = (w + 1) % NM;
    step();
    chk("rel_grant0", grant, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NM-1:0] pend;
    int w;
    rst_n = 1'b0;
    tag   = '0;
    s_ack = '0;
    m_addr = '0; m_wdata = '0; m_we = '0; m_sel = '0; m_stb = '0; m_cyc = '0;
    repeat (2) step();
    s_ack = '1;
    #1;
    chk("rst_grant", {grant, fx_grant}, 0);
    chk("rst_outs", {s_stb, s_cyc, m_ack, m_err}, 0);
    chk("rst_fx_outs", {fx_m_rdata, fx_ack, fx_err, fx_s_stb, fx_s_cyc}, 0);
    chk("rst_fx_bus", {fx_s_addr, fx_s_wdata, fx_s_we, fx_s_sel}, 0);
    s_ack = '0;
    rst_n = 1'b1;
    step();

    // Arbitration, both modes side by side.
    set_m(0, 1, 0, 32'h0); set_m(1, 1, 0, 32'h0);
    step();
    chk("arb_first_rr", grant, 128'(1 << pick(2'b11)));
    chk("arb_first_fx", fx_grant, 2'b01);
    release_m(0);
    step();
    chk("arb_second_rr", grant, 2'b10);
    chk("arb_second_fx", fx_grant, 2'b10);
    release_m(1);
    set_m(0, 1, 0, 32'h0); set_m(1, 1, 0, 32'h0);
    step();
    chk("arb_third_rr", grant, 128'(1 << pick(2'b11)));
    chk("arb_third_fx", fx_grant, 2'b01);
    set_m(1, 0, 0, 32'h0);
    release_m(0);
    set_m(0, 1, 0, 32'h0); set_m(1, 1, 0, 32'h0);
    step();
    chk("arb_rr_rotated", grant, 2'b10);
    chk("arb_fx_fixed", fx_grant, 2'b01);
    set_m(0, 0, 0, 32'h0);
    release_m(1);

    // Read from slave 1 with a two-cycle ack.
    set_m(0, 1, 1, 32'h0001_0004);
    step();
    chk("rd_grant", grant, 2'b01);
    hit_xfer(0, 2);
    release_m(0);

    // Decode miss: single error pulse, grant kept.
    set_m(1, 1, 1, 32'h0005_0000);
    step();
    chk("miss_grant", grant, 2'b10);
    err_xfer(1);
    m_stb[1] = 1'b0;
    step();
    chk("err_once", m_err, 0);
    chk("err_grant_kept", grant, 2'b10);
    release_m(1);

    // Slave 2 never acks: timeout after 16 strobe cycles.
    set_m(0, 1, 1, 32'h0002_0000);
    step();
    for (int c = 0; c < 16; c++) begin
      chk("tmo_stb", s_stb, 3'b100);
      chk("tmo_noerr", m_err, 0);
      step();
    end
    chk("tmo_err", m_err, 2'b01);
    chk("tmo_abandon", {s_stb, s_cyc}, 0);
    release_m(0);

    // Burst of four acked strobes is not pre-empted.
    set_m(0, 1, 1, 32'h0000_0010);
    step();
    chk("burst_grant", grant, 2'b01);
    set_m(1, 1, 1, 32'h0001_0000);
    for (int b = 0; b < 4; b++) begin
      tag = $urandom;
      s_ack = 3'b001;
      #1;
      chk("burst_ack", m_ack, 2'b01);
      chk("burst_hold", grant, 2'b01);
      step();
    end
    s_ack = '0;
    release_m(0);
    step();
    chk("burst_handover", grant, 2'b10);
    hit_xfer(1, 0);
    release_m(1);

    // Reset mid-transfer; late ack must not leak.
    set_m(0, 1, 1, 32'h0000_0020);
    step();
    chk("pre_rst_stb", s_stb, 3'b001);
    rst_n = 1'b0;
    s_ack = 3'b001;
    #1;
    chk("in_rst_quiet", {s_stb, s_cyc, m_ack, m_err}, 0);
    step();
    rst_n = 1'b1;
    set_m(0, 0, 0, 32'h0);
    exp_ptr = 0;
    #1;
    chk("post_rst_grant", grant, 0);
    chk("post_rst_quiet", {s_stb, m_ack}, 0);
    s_ack = '0;
    step();

    // Randomized transactions against the model.
    for (int it = 0; it < 40; it++) begin
      pend = NM'($urandom_range(1, 3));
      for (int m = 0; m < NM; m++) begin
        if (pend[m]) begin
          int r;
          logic [31:0] a;
          r = $urandom_range(0, 3);
          if (r < 3) a = (32'(r) << 16) | ($urandom & 32'h0000_FFFC);
          else       a = ((32'd3 + 32'($urandom_range(0, 100))) << 16) | ($urandom & 32'h0000_FFFC);
          set_m(m, 1, 1, a);
        end
      end
      step();
      while (pend != 0) begin
        w = pick(pend);
        chk("rnd_grant", grant, 128'(1 << w));
        if (exp_slave(addr_m[w]) < 0) err_xfer(w);
        else                          hit_xfer(w, $urandom_range(0, 3));
        pend[w] = 1'b0;
        release_m(w);
        if (pend != 0) step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_interconnect.md
WB_INTERCONNECT -- requirements
Module: wb_interconnect

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 2: number of Wishbone masters.
REQ-002 The block SHALL have parameter NUM_SLAVES, default 3: number of Wishbone slaves.
REQ-003 The block SHALL have parameters WB_DATA_WIDTH / WB_ADDR_WIDTH / WB_SEL_WIDTH, defaults 32 / 32 / 4: bus widths.
REQ-004 The block SHALL have parameter SLAVE_BASE, default {32'h0002_0000, 32'h0001_0000, 32'h0000_0000}: packed per-slave base address, slave 0 in the LSBs.
REQ-005 The block SHALL have parameter SLAVE_MASK, default 3 x 32'hFFFF_0000: packed per-slave decode mask.
REQ-006 The block SHALL have parameter ARB_MODE, default 0: 0 selects round-robin, 1 selects fixed priority (lowest index wins).
REQ-007 The block SHALL have parameter TIMEOUT_CYCLES, default 16: maximum number of strobe cycles without an ack.
REQ-008 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-009 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-low.
REQ-010 The block SHALL have master-side inputs m_addr_i, m_data_i, m_we_i, m_sel_i, m_stb_i and m_cyc_i, each NUM_MASTERS times its field width, packed.
REQ-011 The block SHALL have master-side outputs m_data_o (NUM_MASTERS x DW), m_ack_o (NUM_MASTERS) and m_err_o (NUM_MASTERS).
REQ-012 The block SHALL have shared slave-side outputs s_addr_o (AW), s_data_o (DW), s_we_o (1) and s_sel_o (SW).
REQ-013 The block SHALL have per-slave outputs s_stb_o and s_cyc_o (NUM_SLAVES each), and per-slave inputs s_ack_i (NUM_SLAVES) and s_data_i (NUM_SLAVES x DW).
REQ-014 The block SHALL have output grant_o, NUM_MASTERS bits: one-hot registered grant, all zero when idle.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUS and ERR.
REQ-016 In IDLE, when any m_cyc_i is high, the block SHALL register the winner into grant_o and enter BUS on the next edge; grant latency is 1 cycle.
REQ-017 In round-robin mode, the search SHALL start at pointer rr_ptr; on release, rr_ptr SHALL become the granted index + 1, modulo NUM_MASTERS.
REQ-018 Simultaneous requests SHALL be resolved by rr_ptr (ARB_MODE 0) or by lowest index (ARB_MODE 1).
REQ-019 A grant SHALL be held while the granted master's m_cyc_i stays high, so multi-strobe bursts are not pre-empted; when that m_cyc_i falls, the block SHALL return to IDLE and clear grant_o.
REQ-020 In BUS, the granted master's addr, data, we and sel SHALL drive the s_*_o outputs combinationally; while idle, those outputs SHALL be zero.
REQ-021 Slave j is hit when (addr & MASK_j) == BASE_j; on overlapping hits, the lowest index SHALL win.
REQ-022 Only the hit slave SHALL see s_cyc_o and s_stb_o, each equal to the granted master's cyc and stb.
REQ-023 m_ack_o and m_data_o of the granted master SHALL be combinational copies of the hit slave's ack and data; all other masters SHALL see ack = 0, err = 0 and data = 0.
REQ-024 On a decode miss with stb high in BUS, no slave SHALL be strobed, the block SHALL enter ERR, and m_err_o SHALL pulse high for exactly one cycle in ERR before returning to BUS.
REQ-025 The timeout counter SHALL count cycles in BUS with stb high and no ack, and SHALL clear on ack, on stb low, or on leaving BUS.
REQ-026 When the timeout counter reaches TIMEOUT_CYCLES - 1, the block SHALL enter ERR; in ERR, all s_stb_o and s_cyc_o SHALL be low (the slave is abandoned) and m_err_o SHALL pulse for one cycle.
REQ-027 If m_cyc_i drops while in ERR, the block SHALL go to IDLE after the err pulse.
REQ-028 m_ack_o and m_err_o SHALL never be high in the same cycle.

Reset
REQ-029 With rst_i low at an edge, the block SHALL set state IDLE, grant_o 0, rr_ptr 0 and the timeout counter 0.
REQ-030 During reset, all s_stb_o, s_cyc_o, m_ack_o and m_err_o SHALL be 0, including when reset arrives mid-transfer; no ack SHALL be forwarded in the cycle after reset.

Structure
REQ-031 Package wb_ic_pkg SHALL hold the FSM state enum, the ARB_MODE constants (ARB_RR, ARB_FIXED) and the default decode map constants.
REQ-032 A single sub-module, wb_rr_arbiter, SHALL contain the request vector, rr_ptr, the mode select and the one-hot grant logic.

Verification
REQ-033 Master 0 reads 0x0001_0004 with the slave 1 ack 2 cycles after stb -> s_stb_o = 3'b010, m_ack_o[0] = 1 carrying slave 1 data, and m_ack_o[1] = 0.
REQ-034 Both m_cyc_i rise in the same cycle from reset -> grant_o = 01; after master 0 releases, grant_o = 10; after master 1 releases and both request again, grant_o = 01 (round-robin). With ARB_MODE = 1, grant_o = 01 every time.
REQ-035 Master 1 strobes 0x0005_0000 -> no s_stb_o, m_err_o[1] pulses for exactly 1 cycle, and grant is retained.
REQ-036 Slave 2 never acks -> after 16 strobe cycles, m_err_o pulses once and s_stb_o[2] = 0 in the ERR cycle.
REQ-037 Master 0 runs a burst of 4 strobes while master 1 requests -> grant_o stays 01 until master 0's m_cyc_i falls, then grant_o = 10 one cycle after IDLE.
REQ-038 rst_i is driven low during a pending slave 0 transfer -> the next cycle shows grant_o = 0 and all strobes low, and a late s_ack_i is not forwarded.
